// File: rtl/fc_stream_psram.sv
// Streaming fully-connected layer: y = sat(W*x + b) with one sequential MAC.
// The input vector is buffered locally. Biases and weights are read one 32-bit word at a
// time from the PSRAM controller. Results leave one neuron at a time.
// Optional feature macro: FC_RELU_EN clamps negative results to zero.
module fc_stream_psram #(
  parameter int unsigned INPUT_SIZE  = 320,
  parameter int unsigned OUTPUT_SIZE = 64,
  parameter int unsigned ACTIV_BITS  = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned ACC_BITS    = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [23:0]           weight_base_addr,
  input  logic [23:0]           bias_base_addr,
  output logic                  busy,
  output logic                  done,
  input  logic [ACTIV_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_req,
  output logic [23:0]           mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_done,
  output logic [ACTIV_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned WPW = 32 / ACTIV_BITS;
  localparam int unsigned XW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned NW  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int unsigned LW  = (WPW > 1) ? $clog2(WPW) : 1;
  localparam int unsigned PW  = 2 * ACTIV_BITS;
  localparam int unsigned IW  = 22;

  localparam logic [ACC_BITS-1:0] RoundC = {{(ACC_BITS-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACC_BITS-1:0] SatMax =
    $signed({{(ACC_BITS-ACTIV_BITS+1){1'b0}}, {(ACTIV_BITS-1){1'b1}}});
  localparam logic signed [ACC_BITS-1:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {StIdle, StLoadIn, StRdBias, StRdW, StMac, StEmit, StDone} state_t;

  state_t                       r_state;
  logic                         r_busy, r_done, r_in_ready, r_mem_req, r_out_valid, r_out_last;
  logic [23:0]                  r_mem_addr, r_wbase, r_bbase;
  logic [ACTIV_BITS-1:0]        r_out_data;
  logic [NW-1:0]                r_n;
  logic [XW-1:0]                r_xi;
  logic [LW-1:0]                r_lane;
  logic [IW-1:0]                r_widx;
  logic signed [ACC_BITS-1:0]   r_acc;
  logic [31:0]                  r_word;
  logic signed [ACTIV_BITS-1:0] r_x [INPUT_SIZE];

  logic signed [ACTIV_BITS-1:0] w_lane, w_xv;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_BITS-1:0]   w_acc_next, w_bias_ext, w_sum, w_rnd;
  logic [ACTIV_BITS-1:0]        w_res;

  assign w_lane     = r_word[r_lane*ACTIV_BITS +: ACTIV_BITS];
  assign w_xv       = r_x[r_xi];
  assign w_prod     = w_lane * w_xv;
  assign w_acc_next = r_acc + {{(ACC_BITS-PW){w_prod[PW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_BITS-ACTIV_BITS){mem_rdata[ACTIV_BITS-1]}},
                       mem_rdata[ACTIV_BITS-1:0]};
  assign w_sum      = w_acc_next + RoundC;
  assign w_rnd      = w_sum >>> FRAC_BITS;

  // Round-to-nearest result of the final accumulation, saturated (and clamped when ReLU).
  always_comb begin
    w_res = w_rnd[ACTIV_BITS-1:0];
`ifdef FC_RELU_EN
    if (w_rnd[ACC_BITS-1]) w_res = '0;
    else if (w_rnd > SatMax) w_res = SatMax[ACTIV_BITS-1:0];
`else
    if (w_rnd > SatMax) w_res = SatMax[ACTIV_BITS-1:0];
    else if (w_rnd < SatMin) w_res = SatMin[ACTIV_BITS-1:0];
`endif
  end

  // Input vector buffer; written only during the load phase.
  always_ff @(posedge clk) begin
    if (r_state == StLoadIn && in_valid && r_in_ready) r_x[r_xi] <= in_data;
  end

  // Main controller: load, fetch bias, fetch/MAC each weight word, emit, repeat per neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_wbase     <= '0;
      r_bbase     <= '0;
      r_n         <= '0;
      r_xi        <= '0;
      r_lane      <= '0;
      r_widx      <= '0;
      r_acc       <= '0;
      r_word      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_wbase    <= weight_base_addr;
            r_bbase    <= bias_base_addr;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_n        <= '0;
            r_xi       <= '0;
            r_widx     <= '0;
            r_state    <= StLoadIn;
          end
        end
        StLoadIn: begin
          if (in_valid && r_in_ready) begin
            if (r_xi == XW'(INPUT_SIZE - 1)) begin
              r_xi       <= '0;
              r_in_ready <= 1'b0;
              r_state    <= StRdBias;
            end else begin
              r_xi <= r_xi + XW'(1);
            end
          end
        end
        StRdBias: begin
          // First cycle raises the request; mem_done only counts once it is up.
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_bbase + {IW'(r_n), 2'b00};
          end else if (mem_done) begin
            r_mem_req <= 1'b0;
            r_acc     <= w_bias_ext <<< FRAC_BITS;
            r_xi      <= '0;
            r_state   <= StRdW;
          end
        end
        StRdW: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_wbase + {r_widx, 2'b00};
          end else if (mem_done) begin
            r_mem_req <= 1'b0;
            r_word    <= mem_rdata;
            r_lane    <= '0;
            r_widx    <= r_widx + IW'(1);
            r_state   <= StMac;
          end
        end
        StMac: begin
          r_acc <= w_acc_next;
          r_xi  <= r_xi + XW'(1);
          if (r_lane == LW'(WPW - 1)) begin
            r_lane <= '0;
            if (r_xi == XW'(INPUT_SIZE - 1)) begin
              r_out_data  <= w_res;
              r_out_valid <= 1'b1;
              r_out_last  <= (r_n == NW'(OUTPUT_SIZE - 1));
              r_state     <= StEmit;
            end else begin
              r_state <= StRdW;
            end
          end else begin
            r_lane <= r_lane + LW'(1);
          end
        end
        StEmit: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_n == NW'(OUTPUT_SIZE - 1)) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_n     <= r_n + NW'(1);
              r_state <= StRdBias;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
